// File: rtl/knn_pkg.sv
// Shared types and default sizes for the streaming top-K distance selector.
// The optional majority vote is enabled by defining KNN_VOTE_EN.
package knn_pkg;

    // Default geometry: retained entries, distance width, label width.
    localparam int KNN_K      = 8;
    localparam int KNN_W      = 16;
    localparam int KNN_TYPE_W = 3;

    // Controller states. VOTE is only entered when KNN_VOTE_EN is defined.
    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        VOTE   = 2'd1,
        HOLD   = 2'd2
    } state_e;

    // One retained entry at the default geometry.
    typedef struct packed {
        logic                  valid;
        logic [KNN_W-1:0]      distance;
        logic [KNN_TYPE_W-1:0] label;
    } slot_t;

endpackage

// File: rtl/topk_slot.sv
// One entry of the sorted insertion register: holds a sample, compares it
// against the incoming sample and picks hold / take-new / shift-from-above.
module topk_slot #(
    parameter int W      = 16,
    parameter int TYPE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              insert_i,
    input  logic              ascending_i,
    input  logic [W-1:0]      new_distance_i,
    input  logic [TYPE_W-1:0] new_type_i,
    input  logic              prev_valid_i,
    input  logic [W-1:0]      prev_distance_i,
    input  logic [TYPE_W-1:0] prev_type_i,
    input  logic              prev_beats_i,
    output logic              valid_o,
    output logic [W-1:0]      distance_o,
    output logic [TYPE_W-1:0] type_o,
    output logic              beats_o
);

    logic              valid_q;
    logic [W-1:0]      distance_q;
    logic [TYPE_W-1:0] type_q;

    // Strict compare keeps equal distances in arrival order; an empty slot always loses.
    always_comb begin
        beats_o = !valid_q ||
                  (ascending_i ? (new_distance_i < distance_q) : (new_distance_i > distance_q));
    end

    // Take the new sample where it first wins, shift the upper neighbour in below that point.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            distance_q <= '0;
            type_q     <= '0;
        end else if (clear_i) begin
            valid_q    <= 1'b0;
            distance_q <= '0;
            type_q     <= '0;
        end else if (insert_i && beats_o) begin
            if (prev_beats_i) begin
                valid_q    <= prev_valid_i;
                distance_q <= prev_distance_i;
                type_q     <= prev_type_i;
            end else begin
                valid_q    <= 1'b1;
                distance_q <= new_distance_i;
                type_q     <= new_type_i;
            end
        end
    end

    assign valid_o    = valid_q;
    assign distance_o = distance_q;
    assign type_o     = type_q;

endmodule

// File: rtl/distance_topk_sort.sv
// Streaming top-K distance selector: keeps the K best samples of a frame in
// sorted order and presents them once the frame's last beat is accepted.
// Define KNN_VOTE_EN to add a majority-class vote (out_class) before output.
//
// Handshakes: a beat transfers on a rising edge where valid and ready are both
// high; valid holds its payload stable until that edge, ready never depends on valid.
module distance_topk_sort
    import knn_pkg::*;
#(
    parameter int K      = KNN_K,
    parameter int W      = KNN_W,
    parameter int TYPE_W = KNN_TYPE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ascending,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [W-1:0]             in_distance,
    input  logic [TYPE_W-1:0]        in_type,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W*K-1:0]           out_distance_array,
    output logic [TYPE_W*K-1:0]      out_type_array,
    output logic [$clog2(K+1)-1:0]   out_count
`ifdef KNN_VOTE_EN
    ,
    output logic [TYPE_W-1:0]        out_class
`endif
);

    localparam int CW = $clog2(K+1);

    state_e          state_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [CW-1:0]   count_q;
    logic            asc_q;
    logic            in_frame_q;

    logic            accept;
    logic            clear;
    logic            mode;

    logic [K-1:0]      slot_valid;
    logic [K-1:0]      slot_beats;
    logic [W-1:0]      slot_dist [K];
    logic [TYPE_W-1:0] slot_type [K];

    assign accept = in_valid && in_ready_q;
    assign clear  = (state_q == HOLD) && out_ready;
    // First beat of a frame uses the live mode input; later beats use the latched copy.
    assign mode   = in_frame_q ? asc_q : ascending;

    for (genvar i = 0; i < K; i++) begin : g_slot
        logic              pv;
        logic [W-1:0]      pd;
        logic [TYPE_W-1:0] pt;
        logic              pb;

        if (i == 0) begin : g_head
            assign pv = 1'b0;
            assign pd = '0;
            assign pt = '0;
            assign pb = 1'b0;
        end else begin : g_link
            assign pv = slot_valid[i-1];
            assign pd = slot_dist[i-1];
            assign pt = slot_type[i-1];
            assign pb = slot_beats[i-1];
        end

        topk_slot #(
            .W      (W),
            .TYPE_W (TYPE_W)
        ) u_slot (
            .clk             (clk),
            .rst             (rst),
            .clear_i         (clear),
            .insert_i        (accept),
            .ascending_i     (mode),
            .new_distance_i  (in_distance),
            .new_type_i      (in_type),
            .prev_valid_i    (pv),
            .prev_distance_i (pd),
            .prev_type_i     (pt),
            .prev_beats_i    (pb),
            .valid_o         (slot_valid[i]),
            .distance_o      (slot_dist[i]),
            .type_o          (slot_type[i]),
            .beats_o         (slot_beats[i])
        );
    end

`ifdef KNN_VOTE_EN
    logic [TYPE_W-1:0] vote_c_q;
    logic [CW-1:0]     vote_max_q;
    logic [TYPE_W-1:0] vote_class_q;
    logic [CW-1:0]     vote_cnt;

    // Count the valid slots whose label equals the class under test this cycle.
    always_comb begin
        vote_cnt = '0;
        for (int i = 0; i < K; i++) begin
            if (slot_valid[i] && (slot_type[i] == vote_c_q)) begin
                vote_cnt = vote_cnt + CW'(1);
            end
        end
    end

    assign out_class = vote_class_q;
`endif

    // Frame controller: accept beats, optionally vote, hold the result until consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ACCEPT;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            count_q     <= '0;
            asc_q       <= 1'b1;
            in_frame_q  <= 1'b0;
`ifdef KNN_VOTE_EN
            vote_c_q     <= '0;
            vote_max_q   <= '0;
            vote_class_q <= '0;
`endif
        end else begin
            case (state_q)
                ACCEPT: begin
                    if (accept) begin
                        // Slot K-1 is beaten by every sample until the register is full.
                        if (slot_beats[K-1] && (count_q != CW'(K))) begin
                            count_q <= count_q + CW'(1);
                        end
                        if (!in_frame_q) begin
                            asc_q <= ascending;
                        end
                        in_frame_q <= !in_last;
                        if (in_last) begin
                            in_ready_q <= 1'b0;
`ifdef KNN_VOTE_EN
                            state_q      <= VOTE;
                            vote_c_q     <= '0;
                            vote_max_q   <= '0;
                            vote_class_q <= '0;
`else
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
`endif
                        end
                    end
                end
`ifdef KNN_VOTE_EN
                VOTE: begin
                    // Strictly greater keeps the lower class index on a tie.
                    if (vote_cnt > vote_max_q) begin
                        vote_max_q   <= vote_cnt;
                        vote_class_q <= vote_c_q;
                    end
                    vote_c_q <= vote_c_q + TYPE_W'(1);
                    if (vote_c_q == {TYPE_W{1'b1}}) begin
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                    end
                end
`endif
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= ACCEPT;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        count_q     <= '0;
                    end
                end
                default: begin
                    state_q <= ACCEPT;
                end
            endcase
        end
    end

    // Flatten the slot register onto the output buses, slot 0 in the low bits.
    always_comb begin
        out_distance_array = '0;
        out_type_array     = '0;
        for (int i = 0; i < K; i++) begin
            out_distance_array[i*W +: W]          = slot_dist[i];
            out_type_array[i*TYPE_W +: TYPE_W]    = slot_type[i];
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_distance_topk_sort.sv
// Bench for distance_topk_sort at K=4, W=16, TYPE_W=3. Build with KNN_VOTE_EN
// defined to also cover the majority-vote path and its latency.
module tb_distance_topk_sort;

  localparam int K  = 4;
  localparam int W  = 16;
  localparam int TW = 3;
  localparam int CW = $clog2(K+1);
  localparam int RW = K*W + K*TW + CW + TW;
`ifdef KNN_VOTE_EN
  localparam int LAT = 1 + (1 << TW);
`else
  localparam int LAT = 1;
`endif

  logic            clk;
  logic            rst_n;
  logic            ascending;
  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic [W-1:0]    in_distance;
  logic [TW-1:0]   in_type;
  logic            out_valid;
  logic            out_ready;
  logic [W*K-1:0]  out_distance_array;
  logic [TW*K-1:0] out_type_array;
  logic [CW-1:0]   out_count;
`ifdef KNN_VOTE_EN
  logic [TW-1:0]   out_class;
`endif

  distance_topk_sort #(.K(K), .W(W), .TYPE_W(TW)) dut (
    .clk                (clk),
    .rst                (rst_n),
    .ascending          (ascending),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_last            (in_last),
    .in_distance        (in_distance),
    .in_type            (in_type),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_distance_array (out_distance_array),
    .out_type_array     (out_type_array),
    .out_count          (out_count)
`ifdef KNN_VOTE_EN
    ,
    .out_class          (out_class)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  typedef struct {
    logic [W-1:0]  d;
    logic [TW-1:0] t;
  } smp_t;

  smp_t           frame_q[$];
  logic           frame_asc;
  logic [RW-1:0]  exp_q[$];
  logic [RW-1:0]  cmp_e;
  int             checks = 0;
  int             errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Whole-frame view: stable-sort every sample of the frame, keep the first K,
  // and take the most frequent kept label (lowest label on a tie).
  function automatic logic [RW-1:0] model_result(input logic asc);
    int            n;
    int            kept;
    int            best;
    int            bc;
    bit            used[];
    int            votes[1 << TW];
    logic [K*W-1:0]  d;
    logic [K*TW-1:0] t;
    n    = frame_q.size();
    kept = (n < K) ? n : K;
    used = new[n];
    d    = '0;
    t    = '0;
    for (int c = 0; c < (1 << TW); c++) votes[c] = 0;
    for (int s = 0; s < kept; s++) begin
      best = -1;
      for (int j = 0; j < n; j++) begin
        if (!used[j]) begin
          if (best < 0) best = j;
          else if (asc ? (frame_q[j].d < frame_q[best].d) : (frame_q[j].d > frame_q[best].d)) best = j;
        end
      end
      used[best] = 1'b1;
      d[s*W +: W]   = frame_q[best].d;
      t[s*TW +: TW] = frame_q[best].t;
      votes[int'(frame_q[best].t)]++;
    end
    bc = 0;
    for (int c = 1; c < (1 << TW); c++) begin
      if (votes[c] > votes[bc]) bc = c;
    end
    return {d, t, CW'(kept), TW'(bc)};
  endfunction

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (in_ready && out_valid) begin
        errors++;
        $display("FAIL ready_valid_overlap: in_ready=%0b out_valid=%0b, must not both be 1", in_ready, out_valid);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: out_valid=1 with no expected frame");
        end else begin
          cmp_e = exp_q[0];
          chk("sb_distance", out_distance_array, cmp_e[RW-1 -: K*W]);
          chk("sb_type", out_type_array, cmp_e[CW+TW+K*TW-1 -: K*TW]);
          chk("sb_count", out_count, cmp_e[CW+TW-1 -: CW]);
`ifdef KNN_VOTE_EN
          chk("sb_class", out_class, cmp_e[TW-1:0]);
`endif
        end
      end
    end
  end

  // Retire the expected frame on the edge where the result is consumed.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [W-1:0] d, input logic [TW-1:0] t, input logic last, input logic asc);
    int   waitc;
    smp_t s;
    waitc       = 0;
    in_valid    = 1'b1;
    in_distance = d;
    in_type     = t;
    in_last     = last;
    ascending   = asc;
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waitc);
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    if (frame_q.size() == 0) frame_asc = asc;
    s.d = d;
    s.t = t;
    frame_q.push_back(s);
    if (last) begin
      exp_q.push_back(model_result(frame_asc));
      frame_q.delete();
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called one negedge after the last beat: measure cycles until out_valid.
  task automatic wait_result(input string name);
    int lat;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk(name, lat, LAT);
  endtask

  task automatic check_lit(input string name, input logic [63:0] d, input logic [63:0] t, input logic [63:0] c);
    chk({name, "_dist"}, out_distance_array, d);
    chk({name, "_type"}, out_type_array, t);
    chk({name, "_count"}, out_count, c);
  endtask

  task automatic consume(input int hold);
    logic [W*K-1:0] d0;
    d0        = out_distance_array;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_stable", out_distance_array, d0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_in_ready", in_ready, 1'b1);
    chk("post_hs_out_valid", out_valid, 1'b0);
    chk("post_hs_count", out_count, 0);
    chk("post_hs_dist", out_distance_array, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n       = 1'b0;
    ascending   = 1'b1;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    in_distance = '0;
    in_type     = '0;
    out_ready   = 1'b0;
    frame_asc   = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_count", out_count, 0);
    chk("reset_dist", out_distance_array, 0);
    chk("reset_type", out_type_array, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);

    // 1. ascending, duplicate distances keep arrival order, worse sample dropped
    send_beat(16'd9, 3'd1, 1'b0, 1'b1);
    send_beat(16'd3, 3'd2, 1'b0, 1'b1);
    send_beat(16'd7, 3'd3, 1'b0, 1'b1);
    send_beat(16'd3, 3'd4, 1'b0, 1'b1);
    send_beat(16'd1, 3'd5, 1'b0, 1'b1);
    send_beat(16'd12, 3'd6, 1'b1, 1'b1);
    wait_result("t1_latency");
    check_lit("t1", {16'd7, 16'd3, 16'd3, 16'd1}, {3'd3, 3'd4, 3'd2, 3'd5}, 4);
    consume(0);

    // 2. short frame, then single-beat frame
    send_beat(16'd5, 3'd1, 1'b0, 1'b1);
    send_beat(16'd2, 3'd0, 1'b1, 1'b1);
    wait_result("t2_latency");
    check_lit("t2", {16'd0, 16'd0, 16'd5, 16'd2}, {3'd0, 3'd0, 3'd1, 3'd0}, 2);
    consume(0);
    send_beat(16'd8, 3'd7, 1'b1, 1'b1);
    wait_result("t2b_latency");
    check_lit("t2b", {16'd0, 16'd0, 16'd0, 16'd8}, {3'd0, 3'd0, 3'd0, 3'd7}, 1);
    consume(0);

    // 3. descending, mode input toggled after the first beat
    send_beat(16'd4, 3'd1, 1'b0, 1'b0);
    send_beat(16'd10, 3'd2, 1'b0, 1'b1);
    send_beat(16'd6, 3'd3, 1'b0, 1'b0);
    send_beat(16'd10, 3'd4, 1'b0, 1'b1);
    send_beat(16'd2, 3'd5, 1'b1, 1'b1);
    wait_result("t3_latency");
    check_lit("t3", {16'd4, 16'd6, 16'd10, 16'd10}, {3'd1, 3'd3, 3'd4, 3'd2}, 4);
    consume(0);

    // 4. backpressure for 20 cycles, then a back-to-back frame
    send_beat(16'd100, 3'd1, 1'b0, 1'b1);
    send_beat(16'd50, 3'd2, 1'b0, 1'b1);
    send_beat(16'd75, 3'd3, 1'b1, 1'b1);
    wait_result("t4_latency");
    check_lit("t4", {16'd0, 16'd100, 16'd75, 16'd50}, {3'd0, 3'd1, 3'd3, 3'd2}, 3);
    consume(20);
    send_beat(16'd6, 3'd6, 1'b0, 1'b0);
    send_beat(16'd4, 3'd4, 1'b1, 1'b0);
    wait_result("t4b_latency");
    check_lit("t4b", {16'd0, 16'd0, 16'd4, 16'd6}, {3'd0, 3'd0, 3'd4, 3'd6}, 2);
    consume(0);

    // 5. reset in the middle of a frame
    send_beat(16'd50, 3'd1, 1'b0, 1'b1);
    send_beat(16'd40, 3'd2, 1'b0, 1'b1);
    send_beat(16'd30, 3'd3, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", out_valid, 1'b0);
    chk("t5_rst_count", out_count, 0);
    chk("t5_rst_dist", out_distance_array, 0);
    frame_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(16'd20, 3'd1, 1'b0, 1'b1);
    send_beat(16'd10, 3'd2, 1'b1, 1'b1);
    wait_result("t5_latency");
    check_lit("t5", {16'd0, 16'd0, 16'd20, 16'd10}, {3'd0, 3'd0, 3'd1, 3'd2}, 2);
    consume(0);

    // 6. vote frames: tie between 2 and 5, then a clear majority of 3
    send_beat(16'd1, 3'd2, 1'b0, 1'b1);
    send_beat(16'd2, 3'd5, 1'b0, 1'b1);
    send_beat(16'd3, 3'd2, 1'b0, 1'b1);
    send_beat(16'd4, 3'd5, 1'b1, 1'b1);
    wait_result("t6_latency");
    check_lit("t6", {16'd4, 16'd3, 16'd2, 16'd1}, {3'd5, 3'd2, 3'd5, 3'd2}, 4);
`ifdef KNN_VOTE_EN
    chk("t6_class", out_class, 3'd2);
`endif
    consume(0);
    send_beat(16'd1, 3'd3, 1'b0, 1'b1);
    send_beat(16'd2, 3'd3, 1'b0, 1'b1);
    send_beat(16'd3, 3'd1, 1'b0, 1'b1);
    send_beat(16'd4, 3'd6, 1'b1, 1'b1);
    wait_result("t6b_latency");
    check_lit("t6b", {16'd4, 16'd3, 16'd2, 16'd1}, {3'd6, 3'd1, 3'd3, 3'd3}, 4);
`ifdef KNN_VOTE_EN
    chk("t6b_class", out_class, 3'd3);
`endif
    consume(0);

    chk("end_queue_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
